// File: rtl/note_detector.sv
// Tone period measurement and C/E/G/A note lock detector.
// Optional NOTE_DETECTOR_GLITCH_FILTER_EN adds a 4-clk level filter ahead of edge detection.
module note_detector #(
    parameter int CNT_W   = 18,
    parameter int PER_C   = 191133,
    parameter int PER_E   = 151701,
    parameter int PER_G   = 127550,
    parameter int PER_A   = 113636,
    parameter int TOL     = 2048,
    parameter int CONFIRM = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tone_in,
    output logic             note_valid,
    output logic [1:0]       note_id,
    output logic [CNT_W-1:0] period,
    output logic             note_change
);

    localparam int RUN_W = $clog2(CONFIRM + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(CONFIRM);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {StIdle, StMeasure, StLocked} state_e;

    state_e           state_q, state_d;
    logic             sync1_q, sync2_q, hist_q;
    logic             level, rise;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [1:0]       cand_q, cand_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             valid_q, valid_d;
    logic [1:0]       id_q, id_d;
    logic             change_q, change_d;
    logic             m_any;
    logic [1:0]       m_id;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= tone_in;
            sync2_q <= sync1_q;
            hist_q  <= level;
        end
    end

`ifdef NOTE_DETECTOR_GLITCH_FILTER_EN
    logic [1:0] gcnt_q;
    logic       filt_q;

    // Level follows the synchronizer only after 4 consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_q <= 1'b0;
            gcnt_q <= 2'd0;
        end else if (sync2_q != filt_q) begin
            if (gcnt_q == 2'd3) begin
                filt_q <= sync2_q;
                gcnt_q <= 2'd0;
            end else begin
                gcnt_q <= gcnt_q + 2'd1;
            end
        end else begin
            gcnt_q <= 2'd0;
        end
    end

    assign level = filt_q;
`else
    assign level = sync2_q;
`endif

    assign rise = level & ~hist_q;

    function automatic logic in_win(input logic [CNT_W-1:0] p, input int per);
        int pv;
        pv = int'(p);
        return (pv >= per - TOL) && (pv <= per + TOL);
    endfunction

    // Priority C>E>G>A resolves overlapping windows.
    always_comb begin
        m_any = 1'b1;
        m_id  = 2'd0;
        if (in_win(cnt_q, PER_C))      m_id = 2'd0;
        else if (in_win(cnt_q, PER_E)) m_id = 2'd1;
        else if (in_win(cnt_q, PER_G)) m_id = 2'd2;
        else if (in_win(cnt_q, PER_A)) m_id = 2'd3;
        else                           m_any = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            period_q <= '0;
            cand_q   <= 2'd0;
            run_q    <= '0;
            valid_q  <= 1'b0;
            id_q     <= 2'd0;
            change_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            cand_q   <= cand_d;
            run_q    <= run_d;
            valid_q  <= valid_d;
            id_q     <= id_d;
            change_q <= change_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        cand_d   = cand_q;
        run_d    = run_q;
        valid_d  = valid_q;
        id_d     = id_q;
        change_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (rise) begin
                    state_d = StMeasure;
                    cnt_d   = CNT_W'(1);
                end
            end
            default: begin
                if (rise) begin
                    period_d = cnt_q;
                    cnt_d    = CNT_W'(1);
                    if (m_any && (m_id == cand_q)) begin
                        run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + RUN_W'(1);
                        if (state_q == StMeasure && run_d == RUN_MAX) begin
                            state_d  = StLocked;
                            valid_d  = 1'b1;
                            id_d     = cand_q;
                            change_d = 1'b1;
                        end
                    end else begin
                        if (m_any) begin
                            cand_d = m_id;
                            run_d  = RUN_W'(1);
                        end else begin
                            run_d = '0;
                        end
                        valid_d = 1'b0;
                        state_d = StMeasure;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    // No rise within the counter range: tone lost.
                    state_d = StIdle;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                    run_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_comb begin
        note_valid  = valid_q;
        note_id     = id_q;
        period      = period_q;
        note_change = change_q;
    end

endmodule
